// File: rtl/axi_r_fifo_reader.sv
`default_nettype none
// ============================================================================
// Module  : axi_r_fifo_reader
// Brief   : Drains packed R beats from a FIFO into an AXI4 R channel through a
//           2-entry flop-based skid buffer. Optional macro R_LAST_CHECK_EN adds
//           an ARLEN queue and a sticky RLAST-mismatch flag.
// Revision: 1.0
// ============================================================================
module axi_r_fifo_reader #(
    parameter int ID_W   = 8,
    parameter int DATA_W = 32,
    parameter int PKT_W  = ID_W + DATA_W + 3
) (
    input  logic              rclk,
    input  logic              rrst_n,
    input  logic [PKT_W-1:0]  fifo_rdata,
    input  logic              fifo_rempty,
    output logic              fifo_rpop,
    output logic [ID_W-1:0]   RID,
    output logic [DATA_W-1:0] RDATA,
    output logic [1:0]        RRESP,
    output logic              RLAST,
    output logic              RVALID,
    input  logic              RREADY,
    output logic [7:0]        beat_cnt,
    output logic              burst_done,
    input  logic              len_valid,
    output logic              len_ready,
    input  logic [7:0]        len,
    output logic              err_last
);

    localparam int C_PL_W = ID_W + DATA_W + 3;

    localparam logic [1:0] C_EMPTY = 2'd0;
    localparam logic [1:0] C_ONE   = 2'd1;
    localparam logic [1:0] C_TWO   = 2'd2;

    logic [1:0]        r_state;
    logic [C_PL_W-1:0] r_skid;
    logic [C_PL_W-1:0] w_in;
    logic              w_hs;
    logic              w_pop;

    assign w_in = fifo_rdata[C_PL_W-1:0];
    assign w_hs = RVALID && RREADY;
    // A slot freed by this cycle's handshake can be refilled in the same cycle.
    assign w_pop = rrst_n && !fifo_rempty && ((r_state != C_TWO) || w_hs);
    assign fifo_rpop = w_pop;

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            r_state <= C_EMPTY;
            RVALID  <= 1'b0;
            RID     <= '0;
            RDATA   <= '0;
            RRESP   <= '0;
            RLAST   <= 1'b0;
            r_skid  <= '0;
        end else begin
            case (r_state)
                C_EMPTY: begin
                    if (w_pop) begin
                        {RID, RDATA, RRESP, RLAST} <= w_in;
                        RVALID  <= 1'b1;
                        r_state <= C_ONE;
                    end
                end
                C_ONE: begin
                    if (w_pop && !w_hs) begin
                        r_skid  <= w_in;
                        r_state <= C_TWO;
                    end else if (w_pop && w_hs) begin
                        {RID, RDATA, RRESP, RLAST} <= w_in;
                    end else if (w_hs) begin
                        RVALID  <= 1'b0;
                        r_state <= C_EMPTY;
                    end
                end
                C_TWO: begin
                    // Output register always takes the older skid entry first.
                    if (w_hs) begin
                        {RID, RDATA, RRESP, RLAST} <= r_skid;
                        if (w_pop) begin
                            r_skid <= w_in;
                        end else begin
                            r_state <= C_ONE;
                        end
                    end
                end
                default: begin
                    RVALID  <= 1'b0;
                    r_state <= C_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            beat_cnt   <= 8'd0;
            burst_done <= 1'b0;
        end else begin
            burst_done <= w_hs && RLAST;
            if (w_hs) begin
                beat_cnt <= RLAST ? 8'd0 : beat_cnt + 8'd1;
            end
        end
    end

`ifdef R_LAST_CHECK_EN
    logic [7:0] r_lq [4];
    logic [1:0] r_wp;
    logic [1:0] r_rp;
    logic [2:0] r_lcnt;
    logic       r_err;
    logic       w_push;
    logic       w_lpop;
    logic [7:0] w_head;
    logic       w_mis;

    assign len_ready = (r_lcnt != 3'd4);
    assign w_push    = len_valid && len_ready;
    assign w_lpop    = w_hs && RLAST && (r_lcnt != 3'd0);
    assign w_head    = r_lq[r_rp];
    // beat_cnt is the zero-based index of the beat in flight, so it equals ARLEN on the last beat.
    assign w_mis     = (r_lcnt == 3'd0) || (RLAST ? (beat_cnt != w_head) : (beat_cnt == w_head));
    assign err_last  = r_err;

    always_ff @(posedge rclk) begin
        if (w_push) begin
            r_lq[r_wp] <= len;
        end
    end

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            r_wp   <= 2'd0;
            r_rp   <= 2'd0;
            r_lcnt <= 3'd0;
            r_err  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + 2'd1;
            end
            if (w_lpop) begin
                r_rp <= r_rp + 2'd1;
            end
            r_lcnt <= r_lcnt + {2'b00, w_push} - {2'b00, w_lpop};
            if (w_hs && w_mis) begin
                r_err <= 1'b1;
            end
        end
    end
`else
    logic w_unused_len;

    assign w_unused_len = ^{len_valid, len};
    assign len_ready    = 1'b1;
    assign err_last     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axi_r_fifo_reader.sv
`default_nettype none
// ============================================================================
// Module  : tb_axi_r_fifo_reader
// Brief   : Directed self-checking bench for axi_r_fifo_reader with a queue
//           model of the upstream FIFO.
// Revision: 1.0
// ============================================================================
module tb_axi_r_fifo_reader;

    localparam int ID_W   = 8;
    localparam int DATA_W = 32;
    localparam int PKT_W  = ID_W + DATA_W + 3;

    logic              rclk = 1'b0;
    logic              rrst_n;
    logic [PKT_W-1:0]  fifo_rdata;
    logic              fifo_rempty;
    logic              fifo_rpop;
    logic [ID_W-1:0]   RID;
    logic [DATA_W-1:0] RDATA;
    logic [1:0]        RRESP;
    logic              RLAST;
    logic              RVALID;
    logic              RREADY;
    logic [7:0]        beat_cnt;
    logic              burst_done;
    logic              len_valid;
    logic              len_ready;
    logic [7:0]        len;
    logic              err_last;

    logic [PKT_W-1:0]  fq [$];
    logic [PKT_W-1:0]  hs_q [$];
    int                hs_tick [$];
    int                hs_cnt  = 0;
    int                pop_cnt = 0;
    int                tick_no = 0;
    int                n_checks = 0;
    int                n_err    = 0;

    always #5 rclk = ~rclk;

    axi_r_fifo_reader #(.ID_W(ID_W), .DATA_W(DATA_W), .PKT_W(PKT_W)) dut (
        .rclk(rclk), .rrst_n(rrst_n),
        .fifo_rdata(fifo_rdata), .fifo_rempty(fifo_rempty), .fifo_rpop(fifo_rpop),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
        .RVALID(RVALID), .RREADY(RREADY),
        .beat_cnt(beat_cnt), .burst_done(burst_done),
        .len_valid(len_valid), .len_ready(len_ready), .len(len),
        .err_last(err_last)
    );

    function automatic logic [PKT_W-1:0] pk(input logic [7:0] id, input logic [31:0] d,
                                            input logic [1:0] r, input logic l);
        return {id, d, r, l};
    endfunction

    task automatic drive_fifo();
        fifo_rempty = (fq.size() == 0);
        if (fq.size() == 0) fifo_rdata = '0;
        else                fifo_rdata = fq[0];
    endtask

    // Samples pop/handshake just before the edge, then updates the FIFO model after it.
    task automatic tick();
        logic p;
        #1;
        p = fifo_rpop;
        if (RVALID && RREADY) begin
            hs_q.push_back({RID, RDATA, RRESP, RLAST});
            hs_tick.push_back(tick_no);
            hs_cnt++;
        end
        @(posedge rclk);
        tick_no++;
        #1;
        if (p) begin
            void'(fq.pop_front());
            pop_cnt++;
        end
        drive_fifo();
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_hs();
        hs_q.delete();
        hs_tick.delete();
        hs_cnt = 0;
    endtask

    initial begin
        int bad;
        bit mid_done;

        // Reset with a non-empty FIFO
        rrst_n = 1'b0; RREADY = 1'b0; len_valid = 1'b0; len = 8'd0;
        fq.push_back(pk(8'd1, 32'h11, 2'd0, 1'b1));
        drive_fifo();
        repeat (3) tick();
        check("rst_rpop",      64'(fifo_rpop),  64'd0);
        check("rst_rvalid",    64'(RVALID),     64'd0);
        check("rst_beat_cnt",  64'(beat_cnt),   64'd0);
        check("rst_burst",     64'(burst_done), 64'd0);
        check("rst_err_last",  64'(err_last),   64'd0);
        check("rst_rdata",     64'(RDATA),      64'd0);
        check("rst_no_pops",   64'(pop_cnt),    64'd0);

        fq.delete(); drive_fifo();
        rrst_n = 1'b1; RREADY = 1'b1;
        tick();

        // Single beat
        clear_hs();
        fq.push_back(pk(8'd3, 32'hDEADBEEF, 2'd0, 1'b1));
        drive_fifo();
        #1;
        check("single_pop", 64'(fifo_rpop), 64'd1);
        tick();
        check("single_rvalid", 64'(RVALID), 64'd1);
        check("single_rid",    64'(RID),    64'd3);
        check("single_rdata",  64'(RDATA),  64'hDEADBEEF);
        check("single_rresp",  64'(RRESP),  64'd0);
        check("single_rlast",  64'(RLAST),  64'd1);
        check("single_nopop",  64'(fifo_rpop), 64'd0);
        tick();
        check("single_done",     64'(burst_done), 64'd1);
        check("single_beat_cnt", 64'(beat_cnt),   64'd0);
        check("single_rvalid_lo",64'(RVALID),     64'd0);
        check("single_hs_cnt",   64'(hs_cnt),     64'd1);
        tick();
        check("single_done_pulse", 64'(burst_done), 64'd0);

        // Backpressure: only two beats may leave the FIFO
        RREADY = 1'b0; pop_cnt = 0; clear_hs();
        for (int i = 0; i < 4; i++) fq.push_back(pk(8'd5, 32'h100 + i, 2'(i), i == 3));
        drive_fifo();
        repeat (2) tick();
        check("bp_hold_early", 64'(RDATA), 64'h100);
        repeat (3) tick();
        check("bp_pops",      64'(pop_cnt),   64'd2);
        check("bp_nopop",     64'(fifo_rpop), 64'd0);
        check("bp_rvalid",    64'(RVALID),    64'd1);
        check("bp_hold_data", 64'(RDATA),     64'h100);
        check("bp_hold_resp", 64'(RRESP),     64'd0);
        check("bp_fifo_left", 64'(fq.size()), 64'd2);
        RREADY = 1'b1;
        for (int k = 0; k < 10 && hs_cnt < 4; k++) tick();
        check("bp_hs_cnt", 64'(hs_cnt), 64'd4);
        for (int j = 0; j < 4; j++)
            check($sformatf("bp_beat%0d", j), 64'((j < hs_q.size()) ? hs_q[j] : '1),
                  64'(pk(8'd5, 32'h100 + j, 2'(j), j == 3)));
        check("bp_consec",   64'((hs_tick.size() == 4) ? hs_tick[3] - hs_tick[0] : -1), 64'd3);
        check("bp_done",     64'(burst_done), 64'd1);
        check("bp_beat_cnt", 64'(beat_cnt),   64'd0);

        // Streaming: 16 beats back to back
        clear_hs(); mid_done = 1'b0;
        for (int i = 0; i < 16; i++) fq.push_back(pk(8'd7, 32'hA000 + i, 2'd0, i == 15));
        drive_fifo();
        for (int k = 0; k < 24 && hs_cnt < 16; k++) begin
            tick();
            if (hs_cnt == 8 && !mid_done) begin
                check("stream_beat_cnt8", 64'(beat_cnt), 64'd8);
                mid_done = 1'b1;
            end
        end
        check("stream_hs_cnt", 64'(hs_cnt), 64'd16);
        check("stream_consec", 64'((hs_tick.size() == 16) ? hs_tick[15] - hs_tick[0] : -1), 64'd15);
        bad = 0;
        for (int j = 0; j < hs_q.size(); j++)
            if (hs_q[j] !== pk(8'd7, 32'hA000 + j, 2'd0, j == 15)) bad++;
        check("stream_order", 64'(bad), 64'd0);
        check("stream_done",  64'(burst_done), 64'd1);

`ifndef R_LAST_CHECK_EN
        check("nochk_len_ready", 64'(len_ready), 64'd1);
        check("nochk_err_last",  64'(err_last),  64'd0);
`endif

        // Mid-burst reset
        tick();
        clear_hs();
        for (int i = 0; i < 4; i++) fq.push_back(pk(8'd9, 32'hB0 + i, 2'd0, i == 3));
        drive_fifo();
        for (int k = 0; k < 8 && hs_cnt < 2; k++) tick();
        check("mr_beat_cnt2", 64'(beat_cnt), 64'd2);
        check("mr_rvalid",    64'(RVALID),   64'd1);
        rrst_n = 1'b0;
        #1;
        check("mr_rpop_in_rst", 64'(fifo_rpop), 64'd0);
        tick();
        check("mr_rvalid_lo", 64'(RVALID),   64'd0);
        check("mr_beat_cnt0", 64'(beat_cnt), 64'd0);
        check("mr_rdata0",    64'(RDATA),    64'd0);
        fq.delete(); drive_fifo();
        rrst_n = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) fq.push_back(pk(8'd10, 32'hC0 + i, 2'd1, i == 1));
        drive_fifo();
        tick();
        check("mr_next_rvalid", 64'(RVALID),   64'd1);
        check("mr_next_cnt0",   64'(beat_cnt), 64'd0);
        check("mr_next_rresp",  64'(RRESP),    64'd1);
        tick();
        check("mr_next_cnt1",   64'(beat_cnt), 64'd1);
        check("mr_next_data1",  64'(RDATA),    64'hC1);
        tick();
        check("mr_next_done",   64'(burst_done), 64'd1);

`ifdef R_LAST_CHECK_EN
        // Short burst against len=3 must set the sticky flag
        rrst_n = 1'b0; tick(); rrst_n = 1'b1;
        check("chk_err_rst",   64'(err_last),  64'd0);
        check("chk_len_ready", 64'(len_ready), 64'd1);
        len_valid = 1'b1; len = 8'd3;
        tick();
        len_valid = 1'b0;
        clear_hs();
        for (int i = 0; i < 3; i++) fq.push_back(pk(8'd2, 32'hD0 + i, 2'd0, i == 2));
        drive_fifo();
        for (int k = 0; k < 8 && hs_cnt < 3; k++) tick();
        tick();
        check("chk_err_set", 64'(err_last), 64'd1);
        repeat (3) tick();
        check("chk_err_sticky", 64'(err_last), 64'd1);
        rrst_n = 1'b0; tick(); rrst_n = 1'b1;
        check("chk_err_clr", 64'(err_last), 64'd0);
        // Fill the length queue, then a correct 4-beat burst
        len_valid = 1'b1; len = 8'd3;
        repeat (4) tick();
        len_valid = 1'b0;
        #1;
        check("chk_len_full", 64'(len_ready), 64'd0);
        clear_hs();
        for (int i = 0; i < 4; i++) fq.push_back(pk(8'd2, 32'hE0 + i, 2'd0, i == 3));
        drive_fifo();
        for (int k = 0; k < 10 && hs_cnt < 4; k++) tick();
        tick();
        check("chk_err_ok",      64'(err_last),  64'd0);
        check("chk_len_popped",  64'(len_ready), 64'd1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi_r_fifo_reader.md
AXI_R_FIFO_READER -- requirements
Module: axi_r_fifo_reader

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter ID_W, default 8, giving the RID width.
REQ-002 The block SHALL have parameter DATA_W, default 32, giving the RDATA width.
REQ-003 The block SHALL have parameter PKT_W, default ID_W+DATA_W+3, giving the packed FIFO word width.

Ports (name, direction, width, meaning):
REQ-004 The block SHALL have port rclk, input, 1, the single clock.
REQ-005 The block SHALL have port rrst_n, input, 1, a synchronous active-low reset sampled on rclk.
REQ-006 The block SHALL have port fifo_rdata, input, PKT_W, the FIFO head word, packed {RID, RDATA, RRESP[1:0], RLAST} with RLAST at bit 0 and valid when fifo_rempty=0.
REQ-007 The block SHALL have port fifo_rempty, input, 1, the FIFO empty flag.
REQ-008 The block SHALL have port fifo_rpop, output, 1, a one-cycle pop strobe.
REQ-009 The block SHALL have ports RID/RDATA/RRESP/RLAST, output, ID_W/DATA_W/2/1, the AXI4 R payload.
REQ-010 The block SHALL have port RVALID, output, 1, the AXI R valid.
REQ-011 The block SHALL have port RREADY, input, 1, the AXI R ready from the master.
REQ-012 The block SHALL have port beat_cnt, output, 8, the beats delivered in the current burst.
REQ-013 The block SHALL have port burst_done, output, 1, a one-cycle pulse on an RLAST handshake.
REQ-014 The block SHALL have ports len_valid/len_ready/len, input/output/input, 1/1/8, which load the expected ARLEN (macro-gated).
REQ-015 The block SHALL have port err_last, output, 1, a sticky RLAST-mismatch flag (macro-gated).

Function
REQ-016 The block SHALL implement a 2-entry output skid buffer; RVALID and all R payload outputs SHALL be driven directly from flops.
REQ-017 fifo_rpop SHALL equal !fifo_rempty && (buffer entries < 2, counting an entry freed this cycle by RVALID&&RREADY); fifo_rdata SHALL be captured in the same cycle as the pop.
REQ-018 Latency from first !fifo_rempty to RVALID=1 SHALL be 1 cycle.
REQ-019 Sustained throughput SHALL be one beat per cycle while the FIFO is non-empty and RREADY=1.
REQ-020 While RVALID=1 and RREADY=0, the R payload SHALL hold stable and RVALID SHALL NOT drop.
REQ-021 A simultaneous pop and handshake with 2 entries SHALL keep the occupancy at 2 with no loss or reordering.
REQ-022 On an R handshake, beat_cnt SHALL increment (wrapping 255->0); if RLAST=1, beat_cnt SHALL clear to 0 on the next cycle and burst_done SHALL pulse for 1 cycle.
REQ-023 Buffer state machine: EMPTY -> ONE on pop without handshake; ONE -> TWO on pop without handshake; TWO -> ONE on handshake without pop; ONE -> EMPTY on handshake without pop; all other combinations SHALL leave the state unchanged.

Reset
REQ-024 While rrst_n=0 at a rclk edge, RVALID, fifo_rpop, beat_cnt, burst_done and err_last SHALL be 0, the payload flops SHALL be 0, and the buffer and length queue SHALL be emptied.
REQ-025 A reset asserted mid-burst SHALL discard buffered beats; fifo_rpop SHALL be 0 during reset.

Configuration
REQ-026 With macro R_LAST_CHECK_EN defined, the block SHALL include a 4-entry length queue: len is pushed on len_valid&&len_ready, and len_ready=0 when the queue is full.
REQ-027 Under R_LAST_CHECK_EN, on each R handshake err_last SHALL set if (RLAST=1 and beat_cnt!=head len) or (RLAST=0 and beat_cnt==head len) or the queue is empty.
REQ-028 Under R_LAST_CHECK_EN, the head entry SHALL be popped on an RLAST handshake, and a simultaneous push and pop SHALL be legal.
REQ-029 Without R_LAST_CHECK_EN, the queue SHALL be absent, len_ready SHALL be tied to 1 and err_last SHALL be tied to 0.

Verification
REQ-030 Reset: hold rrst_n=0 with fifo_rempty=0 -> fifo_rpop=0, RVALID=0, beat_cnt=0.
REQ-031 Single beat: push {ID=3, DATA=32'hDEADBEEF, RESP=0, LAST=1} with RREADY=1 -> RVALID one cycle later with exact payload; burst_done pulses; beat_cnt returns to 0.
REQ-032 Backpressure: 4-beat burst with RREADY=0 for 5 cycles -> exactly 2 pops, then fifo_rpop=0 and payload stable; on release, 4 beats in order with RLAST on beat 4.
REQ-033 Streaming: 16 beats with RREADY=1 and FIFO never empty -> 16 handshakes in 16 consecutive cycles.
REQ-034 Check (macro on): len=3 loaded, RLAST arrives on beat 3 -> err_last=1 and stays 1 until reset; a correct len=3 burst of 4 beats -> err_last stays 0.
REQ-035 Mid-burst reset after 2 of 4 beats -> RVALID=0 the next cycle; after release, the next burst starts with beat_cnt=0.
